// File: rtl/BwaMemDefines.sv
// Shared AXI definitions for the seeding-engine memory path: response and burst codes
// plus the AR request record carried through the responder's request queue.
package BwaMemDefines;

  localparam int unsigned AXI_ADDR_W = 40;
  localparam int unsigned AXI_ID_W   = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // Only full-width (32-byte) beats are served.
  localparam logic [2:0] AXI_SIZE_32B = 3'd5;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [AXI_ID_W-1:0]   id;
  } ar_req_t;

endpackage

// File: rtl/occ_ar_fifo.sv
// Small synchronous FIFO holding accepted AR requests until the read engine takes them.
// Depth is 2**AW; a push while full is accepted only when a pop happens in the same cycle.
module occ_ar_fifo #(
  parameter int unsigned AW = 2,
  parameter type         T  = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned DEPTH = 2 ** AW;

  T              storage [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = storage[rptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + (AW + 1)'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - (AW + 1)'(1);
      end
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) storage[wptr_q] <= wdata;
  end

endmodule

// File: rtl/occ_axi_rd_responder.sv
// AXI4 read-only slave backed by on-chip memory, standing in for DDR when serving OCC-table
// reads. Requests are queued, served strictly in order, one beat per cycle, through a
// registered memory read and a 2-entry output skid buffer.
// Optional build macro OCC_RESP_RAND_STALL_EN adds LFSR-driven pseudo-random stalls on read
// issue and arready.
module occ_axi_rd_responder
  import BwaMemDefines::*;
#(
  parameter int unsigned       ADDR_W     = 40,
  parameter int unsigned       DATA_W     = 256,
  parameter int unsigned       ID_W       = 1,
  parameter logic [ADDR_W-1:0] BASE       = 40'h01_0000_0000,
  parameter int unsigned       MEM_AW     = 10,
  parameter int unsigned       ARQ_AW     = 2,
  parameter logic [15:0]       STALL_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [2:0]        s_axi_arprot,
  input  logic [3:0]        s_axi_arcache,
  input  logic              s_axi_arlock,
  input  logic [3:0]        s_axi_arqos,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic              mem_we,
  input  logic [MEM_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata
);

  // Word index width: byte offset without the 5 in-word address bits.
  localparam int unsigned WI_W = ADDR_W - 5;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // ---------------------------------------------------------------------------------------
  // Optional pseudo-random backpressure
  // ---------------------------------------------------------------------------------------
  logic stall;

`ifdef OCC_RESP_RAND_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; free-running from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic [15:0] unused_seed;
  assign unused_seed = STALL_SEED;
  assign stall       = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------
  // AR channel and request queue
  // ---------------------------------------------------------------------------------------
  ar_req_t ar_in, ar_head;
  logic    arq_full, arq_empty, arq_push, arq_pop;

  assign ar_in = '{
    addr:  s_axi_araddr,
    len:   s_axi_arlen,
    size:  s_axi_arsize,
    burst: s_axi_arburst,
    id:    s_axi_arid
  };

  assign s_axi_arready = !rst && !arq_full && !stall;
  assign arq_push      = s_axi_arvalid && s_axi_arready;

  occ_ar_fifo #(
    .AW (ARQ_AW),
    .T  (ar_req_t)
  ) u_ar_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (arq_push),
    .wdata (ar_in),
    .pop   (arq_pop),
    .rdata (ar_head),
    .full  (arq_full),
    .empty (arq_empty)
  );

  // Decode of the queue head, used when a burst is loaded.
  logic [ADDR_W-1:0] head_off;
  logic [WI_W-1:0]   head_word;
  logic              head_below, head_slverr;

  assign head_off    = ar_head.addr - BASE;
  assign head_word   = head_off[ADDR_W-1:5];
  assign head_below  = (ar_head.addr < BASE);
  assign head_slverr = (ar_head.size != AXI_SIZE_32B) || ar_head.burst[1];

  logic unused_ok;
  assign unused_ok = ^{s_axi_arprot, s_axi_arcache, s_axi_arlock, s_axi_arqos, head_off[4:0]};

  // ---------------------------------------------------------------------------------------
  // Burst engine
  // ---------------------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [WI_W-1:0] word_q, word_d;
  logic            below_q, below_d;
  logic            slverr_q, slverr_d;
  logic            incr_q, incr_d;
  logic [ID_W-1:0] id_q, id_d;

  logic            issue, space, pop_r, beat_decerr;
  logic [1:0]      beat_resp;
  logic [1:0]      buf_cnt_q;
  logic            rd_valid_q;
  logic [2:0]      credit;

  // Beats already committed: buffered plus the one in the memory read stage. A read may
  // issue only if its data is guaranteed a buffer slot when it returns.
  assign pop_r  = s_axi_rvalid && s_axi_rready;
  assign credit = {1'b0, buf_cnt_q} + {2'b00, rd_valid_q} - {2'b00, pop_r};
  assign space  = (credit < 3'd2);
  assign issue  = (state_q == StBurst) && space && !stall;

  assign beat_decerr = below_q || (word_q >= WI_W'(2 ** MEM_AW));
  assign beat_resp   = beat_decerr ? AXI_RESP_DECERR :
                       slverr_q    ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  // Burst state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      word_q   <= '0;
      below_q  <= 1'b0;
      slverr_q <= 1'b0;
      incr_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      below_q  <= below_d;
      slverr_q <= slverr_d;
      incr_q   <= incr_d;
      id_q     <= id_d;
    end
  end

  // Next burst state; the last beat of a burst can load the next request directly so
  // back-to-back bursts stream without a gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    below_d  = below_q;
    slverr_d = slverr_q;
    incr_d   = incr_q;
    id_d     = id_q;
    arq_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!arq_empty) begin
          arq_pop = 1'b1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (issue) begin
          if (cnt_q == 8'd0) begin
            if (!arq_empty) arq_pop = 1'b1;
            else            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 8'd1;
            if (incr_q) word_d = word_q + WI_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (arq_pop) begin
      cnt_d    = ar_head.len;
      word_d   = head_word;
      below_d  = head_below;
      slverr_d = head_slverr;
      incr_d   = (ar_head.burst == AXI_BURST_INCR);
      id_d     = ar_head.id;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Memory: backdoor write port plus registered read-first read port
  // ---------------------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [2 ** MEM_AW];
  logic [DATA_W-1:0] rd_data_q;
  logic [1:0]        rd_resp_q;
  logic [ID_W-1:0]   rd_id_q;
  logic              rd_last_q;
  logic [DATA_W-1:0] rd_beat_data;

  // Backdoor preload / update port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read; a same-cycle write to this word is seen only by later reads.
  always_ff @(posedge clk) begin
    if (issue) rd_data_q <= mem[word_q[MEM_AW-1:0]];
  end

  // Beat attributes travelling alongside the memory read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_resp_q  <= '0;
      rd_id_q    <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= issue;
      if (issue) begin
        rd_resp_q <= beat_resp;
        rd_id_q   <= id_q;
        rd_last_q <= (cnt_q == 8'd0);
      end
    end
  end

  assign rd_beat_data = (rd_resp_q == AXI_RESP_OKAY) ? rd_data_q : '0;

  // ---------------------------------------------------------------------------------------
  // Output skid buffer (2 entries)
  // ---------------------------------------------------------------------------------------
  logic [DATA_W-1:0] buf_data_q [2];
  logic [1:0]        buf_resp_q [2];
  logic [ID_W-1:0]   buf_id_q   [2];
  logic              buf_last_q [2];
  logic              wr_ptr_q, rd_ptr_q;

  // Capture returning beats and retire accepted ones; entries are cleared on reset so the
  // R payload reads zero until the first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      buf_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_resp_q[i] <= '0;
        buf_id_q[i]   <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      if (rd_valid_q) begin
        buf_data_q[wr_ptr_q] <= rd_beat_data;
        buf_resp_q[wr_ptr_q] <= rd_resp_q;
        buf_id_q[wr_ptr_q]   <= rd_id_q;
        buf_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_r) rd_ptr_q <= ~rd_ptr_q;
      if (rd_valid_q && !pop_r) begin
        buf_cnt_q <= buf_cnt_q + 2'd1;
      end else if (!rd_valid_q && pop_r) begin
        buf_cnt_q <= buf_cnt_q - 2'd1;
      end
    end
  end

  assign s_axi_rvalid = (buf_cnt_q != 2'd0);
  assign s_axi_rdata  = buf_data_q[rd_ptr_q];
  assign s_axi_rresp  = buf_resp_q[rd_ptr_q];
  assign s_axi_rid    = buf_id_q[rd_ptr_q];
  assign s_axi_rlast  = buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_occ_axi_rd_responder.sv
// Self-checking bench for occ_axi_rd_responder: directed and randomized AR bursts checked
// against an address-arithmetic reference model and an in-order expected-beat queue.
module tb_occ_axi_rd_responder;

  localparam logic [39:0] BASE  = 40'h01_0000_0000;
  localparam int          WORDS = 1024;

  typedef struct packed {
    logic [255:0] data;
    logic [1:0]   resp;
    logic         id;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [39:0]  s_axi_araddr = '0;
  logic [7:0]   s_axi_arlen = '0;
  logic [2:0]   s_axi_arsize = 3'd5;
  logic [1:0]   s_axi_arburst = 2'b01;
  logic         s_axi_arid = 1'b0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [255:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rid;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b0;
  logic         mem_we = 1'b0;
  logic [9:0]   mem_waddr = '0;
  logic [255:0] mem_wdata = '0;

  always #5 clk = ~clk;

  occ_axi_rd_responder dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arid    (s_axi_arid),
    .s_axi_arprot  (3'b000),
    .s_axi_arcache (4'b0011),
    .s_axi_arlock  (1'b0),
    .s_axi_arqos   (4'b0000),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata)
  );

  logic [255:0] ref_mem [WORDS];
  beat_t        exp_q[$];
  int           n_check = 0;
  int           n_pass  = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [259:0] got, input logic [259:0] exp);
    n_check++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: beat i of a burst, from byte-address arithmetic on the request.
  function automatic beat_t model_beat(input logic [39:0] a, input logic [7:0] len,
                                       input logic [2:0] sz, input logic [1:0] bu,
                                       input logic id, input int i);
    beat_t           b;
    logic [39:0]     off;
    longint unsigned w;
    b.data = '0;
    b.id   = id;
    b.last = (i == int'(len));
    if (a < BASE) begin
      b.resp = 2'b11;
    end else begin
      off = a - BASE;
      w   = 64'(off) >> 5;
      if (bu == 2'b01) w += longint'(i);
      if (w >= WORDS)                      b.resp = 2'b11;
      else if (sz != 3'd5 || bu > 2'b01)   b.resp = 2'b10;
      else begin
        b.resp = 2'b00;
        b.data = ref_mem[w];
      end
    end
    return b;
  endfunction

  task automatic mem_load(input int word, input logic [255:0] d);
    @(negedge clk);
    mem_we    = 1'b1;
    mem_waddr = 10'(word);
    mem_wdata = d;
    ref_mem[word] = d;
    @(posedge clk);
    #1 mem_we = 1'b0;
  endtask

  task automatic push_model(input logic [39:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic id);
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(model_beat(a, len, sz, bu, id, i));
  endtask

  // Present one AR and hold it until accepted; returns just after the handshake edge.
  task automatic send_ar(input logic [39:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic id);
    int w = 0;
    @(negedge clk);
    s_axi_araddr  = a;
    s_axi_arlen   = len;
    s_axi_arsize  = sz;
    s_axi_arburst = bu;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("ar_accept_in_time", 260'(w < 200), 260'(1));
    @(posedge clk);
    push_model(a, len, sz, bu, id);
    #1 s_axi_arvalid = 1'b0;
  endtask

  // Accept n beats and compare them in order with the expected queue.
  task automatic collect(input int n, input bit rnd, input bit contig);
    int    got = 0, guard = 0, gaps = 0;
    bit    started = 0, held = 0;
    beat_t cur, hb, e;
    while (got < n && guard < 3000) begin
      @(negedge clk);
      guard++;
      cur = {s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast};
      if (held) begin
        chk("hold_rvalid", 260'(s_axi_rvalid), 260'(1));
        chk("hold_payload", 260'(cur), 260'(hb));
      end
      held = 0;
      if (!s_axi_rvalid && started) gaps++;
      s_axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axi_rvalid) begin
        if (s_axi_rready) begin
          started = 1;
          chk("beat_expected", 260'(exp_q.size() > 0), 260'(1));
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          chk("rdata", 260'(cur.data), 260'(e.data));
          chk("rresp", 260'(cur.resp), 260'(e.resp));
          chk("rid", 260'(cur.id), 260'(e.id));
          chk("rlast", 260'(cur.last), 260'(e.last));
          got++;
        end else begin
          held = 1;
          hb   = cur;
        end
      end
    end
    chk("beats_received", 260'(got), 260'(n));
    if (contig) chk("no_bubble", 260'(gaps), 260'(0));
    @(posedge clk);
    #1 s_axi_rready = 1'b0;
  endtask

  logic [255:0] d;
  logic [39:0]  ra [8];
  logic [7:0]   rl [8];
  logic [2:0]   rs [8];
  logic [1:0]   rb [8];
  logic         ri [8];
  int           total, lat, acc, seen;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_arready", 260'(s_axi_arready), 260'(0));
    chk("rst_rvalid", 260'(s_axi_rvalid), 260'(0));
    chk("rst_rpayload", 260'({s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast}), 260'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("arready_after_rst", 260'(s_axi_arready), 260'(1));

    // Preload: words 0..7 patterned, the rest random.
    for (int i = 0; i < WORDS; i++) begin
      if (i < 8) begin
        d = {16{16'(i * 16'h1111)}};
      end else begin
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      end
      mem_load(i, d);
    end

    // INCR words 2..5, with first-beat latency.
    send_ar(BASE + 40'h40, 8'd3, 3'd5, 2'b01, 1'b1);
    lat = 0;
    seen = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (s_axi_rvalid) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    chk("first_rvalid_seen", 260'(seen), 260'(1));
    chk("first_beat_latency", 260'(lat), 260'(3));
    collect(4, 1'b0, 1'b1);
    chk("exp_drained_incr", 260'(exp_q.size()), 260'(0));

    // FIXED repeats word 1.
    send_ar(BASE + 40'h20, 8'd2, 3'd5, 2'b00, 1'b0);
    collect(3, 1'b0, 1'b1);
    chk("exp_drained_fixed", 260'(exp_q.size()), 260'(0));

    // Two back-to-back bursts streaming with rready held high.
    fork
      begin
        send_ar(BASE + 40'h100, 8'd3, 3'd5, 2'b01, 1'b0);
        send_ar(BASE + 40'h000, 8'd2, 3'd5, 2'b01, 1'b1);
      end
      collect(7, 1'b0, 1'b1);
    join
    chk("exp_drained_b2b", 260'(exp_q.size()), 260'(0));

    // Flood single-beat ARs with R stalled. Capacity: 4 queued, 1 held by the engine,
    // 2 already read into the output buffer.
    acc = 0;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      s_axi_araddr  = BASE + 40'($urandom_range(0, 31)) * 40'd32;
      s_axi_arlen   = 8'd0;
      s_axi_arsize  = 3'd5;
      s_axi_arburst = 2'b01;
      s_axi_arid    = 1'($urandom_range(0, 1));
      s_axi_arvalid = 1'b1;
      if (s_axi_arready) begin
        @(posedge clk);
        push_model(s_axi_araddr, 8'd0, 3'd5, 2'b01, s_axi_arid);
        acc++;
      end
      @(negedge clk);
    end
    s_axi_arvalid = 1'b0;
    chk("flood_accepts", 260'(acc), 260'(7));
    chk("arready_low_when_full", 260'(s_axi_arready), 260'(0));
    collect(7, 1'b0, 1'b0);
    @(negedge clk);
    chk("arready_reasserts", 260'(s_axi_arready), 260'(1));
    chk("exp_drained_flood", 260'(exp_q.size()), 260'(0));

    // Boundaries: top-word crossing, below BASE, unsupported size.
    send_ar(BASE + 40'(1022 * 32), 8'd3, 3'd5, 2'b01, 1'b0);
    collect(4, 1'b0, 1'b0);
    send_ar(BASE - 40'h20, 8'd1, 3'd5, 2'b01, 1'b1);
    collect(2, 1'b0, 1'b0);
    send_ar(BASE + 40'h60, 8'd2, 3'd4, 2'b01, 1'b1);
    collect(3, 1'b0, 1'b0);
    chk("exp_drained_errs", 260'(exp_q.size()), 260'(0));

    // 16-beat burst with random rready; low address bits are ignored.
    send_ar(BASE + 40'(8 * 32) + 40'($urandom_range(0, 31)), 8'd15, 3'd5, 2'b01, 1'b1);
    collect(16, 1'b1, 1'b0);
    chk("exp_drained_rand_rready", 260'(exp_q.size()), 260'(0));

    // Random mix of requests, including error cases.
    total = 0;
    for (int j = 0; j < 8; j++) begin
      ra[j] = ($urandom_range(0, 9) == 0) ? BASE - 40'($urandom_range(1, 64))
            : BASE + 40'($urandom_range(0, 1030)) * 40'd32 + 40'($urandom_range(0, 31));
      rl[j] = 8'($urandom_range(0, 7));
      rs[j] = ($urandom_range(0, 4) == 0) ? 3'd4 : 3'd5;
      rb[j] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      ri[j] = 1'($urandom_range(0, 1));
      total += int'(rl[j]) + 1;
    end
    fork
      for (int j = 0; j < 8; j++) send_ar(ra[j], rl[j], rs[j], rb[j], ri[j]);
      collect(total, 1'b1, 1'b0);
    join
    chk("exp_drained_random", 260'(exp_q.size()), 260'(0));

    // Reset in the middle of a burst.
    send_ar(BASE + 40'h100, 8'd15, 3'd5, 2'b01, 1'b0);
    collect(2, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rvalid", 260'(s_axi_rvalid), 260'(0));
    chk("midrst_arready", 260'(s_axi_arready), 260'(0));
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (s_axi_rvalid) seen = 1;
    end
    chk("midrst_no_leftover", 260'(seen), 260'(0));
    chk("midrst_arready_back", 260'(s_axi_arready), 260'(1));
    send_ar(BASE + 40'h60, 8'd1, 3'd5, 2'b01, 1'b1);
    collect(2, 1'b0, 1'b1);
    chk("exp_drained_post_rst", 260'(exp_q.size()), 260'(0));

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
